// File: rtl/regfile_wb_scheduler.sv
// Write-port scheduler for a single-write-port register file: ALU/load arbitration, load FIFO, load scoreboard.
// Optional macro REGFILE_BYPASS_EN enables write-port forwarding outputs; otherwise they are tied to 0.
module regfile_wb_scheduler #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_wb_valid,
  input  logic [4:0]  alu_wb_rd,
  input  logic [31:0] alu_wb_data,
  output logic        alu_stall,
  input  logic        mem_wb_valid,
  input  logic [4:0]  mem_wb_rd,
  input  logic [31:0] mem_wb_data,
  output logic        mem_wb_ready,
  input  logic        iss_fire,
  input  logic        iss_is_load,
  input  logic [4:0]  iss_rs1,
  input  logic [4:0]  iss_rs2,
  input  logic [4:0]  iss_rd,
  output logic        iss_hazard,
  output logic        RegWrite,
  output logic [4:0]  rd,
  output logic [31:0] write_data,
  output logic        fwd_rs1_hit,
  output logic        fwd_rs2_hit,
  output logic [31:0] fwd_data
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {SRC_IDLE, SRC_ALU, SRC_FIFO} src_e;

  logic [4:0]    fifo_rd_q   [FIFO_DEPTH];
  logic [4:0]    fifo_rd_d   [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] age_q, age_d;
  logic [31:0]   pending_q, pending_d;

  src_e        src;
  logic        fifo_nonempty, push, pop;
  logic [4:0]  head_rd;
  logic [31:0] head_data;

  assign fifo_nonempty = (count_q != '0);
  assign head_rd       = fifo_rd_q[rd_ptr_q];
  assign head_data     = fifo_data_q[rd_ptr_q];
  assign mem_wb_ready  = (count_q < CW'(FIFO_DEPTH));
  assign push          = mem_wb_valid && mem_wb_ready;
  assign alu_stall     = (age_q >= AW'(STARVE_LIMIT)) && fifo_nonempty;
  assign iss_hazard    = pending_q[iss_rs1] | pending_q[iss_rs2] | pending_q[iss_rd];

  // A starving FIFO head pre-empts the ALU; an ALU request to x0 leaves the port free.
  always_comb begin
    src        = SRC_IDLE;
    rd         = '0;
    write_data = '0;
    if (alu_stall) begin
      src = SRC_FIFO;
    end else if (alu_wb_valid && alu_wb_rd != 5'd0) begin
      src = SRC_ALU;
    end else if (fifo_nonempty) begin
      src = SRC_FIFO;
    end
    case (src)
      SRC_ALU: begin
        rd         = alu_wb_rd;
        write_data = alu_wb_data;
      end
      SRC_FIFO: begin
        rd         = head_rd;
        write_data = head_data;
      end
      default: ;
    endcase
  end

  assign pop      = (src == SRC_FIFO);
  assign RegWrite = (src != SRC_IDLE) && (rd != 5'd0);

`ifdef REGFILE_BYPASS_EN
  assign fwd_rs1_hit = RegWrite && (rd == iss_rs1);
  assign fwd_rs2_hit = RegWrite && (rd == iss_rs2);
  assign fwd_data    = write_data;
`else
  assign fwd_rs1_hit = 1'b0;
  assign fwd_rs2_hit = 1'b0;
  assign fwd_data    = '0;
`endif

  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q]   = mem_wb_rd;
      fifo_data_d[wr_ptr_q] = mem_wb_data;
      wr_ptr_d              = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Age only accumulates while a buffered load sits at the head without being written.
  always_comb begin
    age_d = age_q;
    if (pop || !fifo_nonempty) begin
      age_d = '0;
    end else if (age_q < AW'(STARVE_LIMIT)) begin
      age_d = age_q + AW'(1);
    end
  end

  // Clear on the write that retires a load, then set so a same-cycle reissue wins.
  always_comb begin
    pending_d = pending_q;
    if (pop && head_rd != 5'd0) begin
      pending_d[head_rd] = 1'b0;
    end
    if (iss_fire && iss_is_load && iss_rd != 5'd0) begin
      pending_d[iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      age_q     <= '0;
      pending_q <= '0;
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      age_q       <= age_d;
      pending_q   <= pending_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized plus directed bench for regfile_wb_scheduler against a queue-based reference model.
module tb_regfile_wb_scheduler;

  localparam int FIFO_DEPTH   = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_wb_valid = 1'b0;
  logic [4:0]  alu_wb_rd = '0;
  logic [31:0] alu_wb_data = '0;
  logic        alu_stall;
  logic        mem_wb_valid = 1'b0;
  logic [4:0]  mem_wb_rd = '0;
  logic [31:0] mem_wb_data = '0;
  logic        mem_wb_ready;
  logic        iss_fire = 1'b0;
  logic        iss_is_load = 1'b0;
  logic [4:0]  iss_rs1 = '0;
  logic [4:0]  iss_rs2 = '0;
  logic [4:0]  iss_rd = '0;
  logic        iss_hazard;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        fwd_rs1_hit;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  logic [31:0] pend = '0;
  int          age = 0;

  regfile_wb_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_stall(alu_stall),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .iss_fire(iss_fire), .iss_is_load(iss_is_load),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_hazard(iss_hazard),
    .RegWrite(RegWrite), .rd(rd), .write_data(write_data),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                               input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                               input logic fire, input logic isld,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] ird);
    alu_wb_valid = av;  alu_wb_rd = ard;  alu_wb_data = adata;
    mem_wb_valid = mv;  mem_wb_rd = mrd;  mem_wb_data = mdata;
    iss_fire = fire;    iss_is_load = isld;
    iss_rs1 = rs1;      iss_rs2 = rs2;    iss_rd = ird;
  endtask

  function automatic logic modelHazard(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] ird);
    return pend[rs1] | pend[rs2] | pend[ird];
  endfunction

  // Compare every output with the model for the current inputs, then advance the model past the next edge.
  task automatic stepModel();
    int          n;
    logic        e_ready, e_stall, e_we, from_fifo, alu_req, e_push;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    n         = q.size();
    e_ready   = (n < FIFO_DEPTH);
    e_stall   = (age >= STARVE_LIMIT) && (n > 0);
    alu_req   = alu_wb_valid && (alu_wb_rd != 5'd0);
    from_fifo = e_stall || (!alu_req && n > 0);
    e_rd      = 5'd0;
    e_data    = 32'd0;
    if (from_fifo) begin
      e_rd   = q[0].rd;
      e_data = q[0].data;
    end else if (alu_req) begin
      e_rd   = alu_wb_rd;
      e_data = alu_wb_data;
    end
    e_we = (e_rd != 5'd0);
    checkOutput("mem_wb_ready", 32'(mem_wb_ready), 32'(e_ready));
    checkOutput("alu_stall", 32'(alu_stall), 32'(e_stall));
    checkOutput("iss_hazard", 32'(iss_hazard), 32'(modelHazard(iss_rs1, iss_rs2, iss_rd)));
    checkOutput("RegWrite", 32'(RegWrite), 32'(e_we));
    checkOutput("rd", 32'(rd), 32'(e_rd));
    checkOutput("write_data", write_data, e_data);
`ifdef REGFILE_BYPASS_EN
    checkOutput("fwd_rs1_hit", 32'(fwd_rs1_hit), 32'(e_we && e_rd == iss_rs1));
    checkOutput("fwd_rs2_hit", 32'(fwd_rs2_hit), 32'(e_we && e_rd == iss_rs2));
    checkOutput("fwd_data", fwd_data, e_data);
`else
    checkOutput("fwd_rs1_hit", 32'(fwd_rs1_hit), 32'd0);
    checkOutput("fwd_rs2_hit", 32'(fwd_rs2_hit), 32'd0);
    checkOutput("fwd_data", fwd_data, 32'd0);
`endif
    e_push = mem_wb_valid && e_ready;
    if (from_fifo || n == 0) age = 0;
    else if (age < STARVE_LIMIT) age = age + 1;
    if (from_fifo) begin
      if (q[0].rd != 5'd0) pend[q[0].rd] = 1'b0;
      void'(q.pop_front());
    end
    if (e_push) q.push_back('{rd: mem_wb_rd, data: mem_wb_data});
    if (iss_fire && iss_is_load && iss_rd != 5'd0) pend[iss_rd] = 1'b1;
  endtask

  task automatic doCycle(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdata,
                         input logic fire, input logic isld,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] ird);
    @(posedge clk);
    #1;
    applyStimulus(av, ard, adata, mv, mrd, mdata, fire, isld, rs1, rs2, ird);
    #1;
    stepModel();
  endtask

  task automatic idleCycle();
    doCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(mem_wb_ready), 32'd1);
    checkOutput({tag, "_stall"}, 32'(alu_stall), 32'd0);
    checkOutput({tag, "_hazard"}, 32'(iss_hazard), 32'd0);
    checkOutput({tag, "_we"}, 32'(RegWrite), 32'd0);
    checkOutput({tag, "_rd"}, 32'(rd), 32'd0);
    checkOutput({tag, "_data"}, write_data, 32'd0);
    checkOutput({tag, "_fwd"}, {fwd_data[31:2], fwd_rs2_hit, fwd_rs1_hit}, 32'd0);
  endtask

  // Directed scenarios first, then a long randomized run against the model.
  initial begin
    logic [4:0]  r1, r2, r3;
    logic        fire;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 rst = 1'b1;
    #1 checkResetValues("reset");
    @(negedge clk) rst = 1'b0;

    // Load round trip through the FIFO and scoreboard.
    doCycle(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5);
    doCycle(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0);
    checkOutput("rt_hazard_set", 32'(iss_hazard), 32'd1);
    doCycle(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    checkOutput("rt_we", 32'(RegWrite), 32'd1);
    checkOutput("rt_rd", 32'(rd), 32'd5);
    checkOutput("rt_data", write_data, 32'hDEADBEEF);
    doCycle(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    checkOutput("rt_hazard_clr", 32'(iss_hazard), 32'd0);

    // Backpressure and starvation under a continuous ALU stream to x3.
    doCycle(1, 3, 32'h100, 1, 9, 32'hA9, 0, 0, 0, 0, 0);
    doCycle(1, 3, 32'h101, 1, 10, 32'hAA, 0, 0, 0, 0, 0);
    for (int i = 0; i < STARVE_LIMIT; i++) begin
      doCycle(1, 3, 32'h200 + 32'(i), 1, 11, 32'hBB, 0, 0, 0, 0, 0);
      checkOutput("bp_ready_full", 32'(mem_wb_ready), 32'd0);
      checkOutput("starve_stall", 32'(alu_stall), 32'(i == STARVE_LIMIT - 1));
    end
    checkOutput("starve_rd", 32'(rd), 32'd9);
    checkOutput("starve_data", write_data, 32'hA9);
    doCycle(1, 3, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("starve_age_reset", 32'(alu_stall), 32'd0);
    checkOutput("starve_alu_wins", 32'(rd), 32'd3);

    // ALU to x0 leaves the slot for the FIFO; a load to x0 retires silently.
    doCycle(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("alu_x0_fifo_rd", 32'(rd), 32'd10);
    idleCycle();
    doCycle(0, 0, 0, 1, 0, 32'h77, 0, 0, 0, 0, 0);
    doCycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("load_x0_we", 32'(RegWrite), 32'd0);
    idleCycle();

    // Forwarding of an ALU write to rs2.
    doCycle(1, 7, 32'h1234, 0, 0, 0, 0, 0, 1, 7, 0);
`ifdef REGFILE_BYPASS_EN
    checkOutput("byp_rs2_hit", 32'(fwd_rs2_hit), 32'd1);
    checkOutput("byp_data", fwd_data, 32'h1234);
`else
    checkOutput("byp_rs2_hit", 32'(fwd_rs2_hit), 32'd0);
    checkOutput("byp_data", fwd_data, 32'd0);
`endif

    // Asynchronous reset mid-operation drops buffered loads and pending bits.
    doCycle(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 12);
    doCycle(1, 4, 32'h44, 1, 12, 32'hC0, 0, 0, 0, 0, 0);
    doCycle(1, 4, 32'h45, 1, 13, 32'hC1, 0, 0, 12, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 12, 0, 0);
    rst = 1'b1;
    #1;
    checkResetValues("midreset");
    q.delete();
    pend = '0;
    age  = 0;
    @(negedge clk) rst = 1'b0;

    for (int c = 0; c < 3000; c++) begin
      r1 = 5'($urandom_range(0, 7));
      r2 = 5'($urandom_range(0, 7));
      r3 = 5'($urandom_range(0, 7));
      fire = ($urandom_range(0, 2) == 0) && !modelHazard(r1, r2, r3);
      doCycle(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
              ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)), $urandom,
              fire, 1'($urandom_range(0, 1)), r1, r2, r3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
